// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the RV64M multiply/divide sequencer: opcodes, funct fields and FSM states.
package muldiv_sequencer_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP_32 = 7'b0111011;
    localparam logic [6:0] FUNCT7_M  = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } m_funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_sequencer_decoder.sv
// Combinational M-extension decoder: classifies an instruction word into op kind and operand signedness.
module muldiv_sequencer_decoder
    import muldiv_sequencer_pkg::*;
(
    input  logic [31:0] insn,
    output logic        is_m,
    output logic        is_word,
    output logic        is_div,
    output logic        is_rem,
    output logic        is_high,
    output logic        sign_a,
    output logic        sign_b
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign unused_fields = ^insn[24:15] ^ ^insn[11:7];

    always_comb begin
        opcode  = insn[6:0];
        funct3  = insn[14:12];
        funct7  = insn[31:25];
        is_word = (opcode == OPC_OP_32);
        // OP-32 only carries MULW and the four divide forms
        is_m    = (funct7 == FUNCT7_M) &&
                  ((opcode == OPC_OP) || (is_word && ((funct3 == F3_MUL) || funct3[2])));
        is_div  = funct3[2];
        is_rem  = funct3[2] & funct3[1];
        is_high = !funct3[2] && (funct3[1:0] != 2'b00);
        sign_a  = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                  (funct3 == F3_DIV) || (funct3 == F3_REM);
        sign_b  = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                  (funct3 == F3_DIV) || (funct3 == F3_REM);
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply (shift-add) / divide (restoring) sequencer, one bit per cycle.
// Build option MULDIV_EARLY_OUT_EN: zero-operand ops skip CALC and complete the cycle after accept.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int HW = XLEN / 2;
    localparam int CW = $clog2(XLEN);

    logic dec_is_m, dec_is_word, dec_is_div, dec_is_rem, dec_is_high, dec_sign_a, dec_sign_b;

    muldiv_sequencer_decoder u_dec (
        .insn    (insn),
        .is_m    (dec_is_m),
        .is_word (dec_is_word),
        .is_div  (dec_is_div),
        .is_rem  (dec_is_rem),
        .is_high (dec_is_high),
        .sign_a  (dec_sign_a),
        .sign_b  (dec_sign_b)
    );

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   hi_q;
    logic [XLEN-1:0] lo_q, opnd_q, result_q;
    logic            word_q, div_q, rem_q, high_q, neg_q, out_valid_q;

    // Operand conditioning: W-ops see only the low half, magnitudes are zero-extended
    logic [XLEN-1:0] wmask, a_ext, b_ext, a_mag, b_mag;
    logic            a_neg, b_neg;

    always_comb begin
        wmask = dec_is_word ? {{HW{1'b0}}, {HW{1'b1}}} : {XLEN{1'b1}};
        a_ext = rs1 & wmask;
        b_ext = rs2 & wmask;
        a_neg = dec_sign_a & (dec_is_word ? rs1[HW-1] : rs1[XLEN-1]);
        b_neg = dec_sign_b & (dec_is_word ? rs2[HW-1] : rs2[XLEN-1]);
        a_mag = a_neg ? (({XLEN{1'b0}} - a_ext) & wmask) : a_ext;
        b_mag = b_neg ? (({XLEN{1'b0}} - b_ext) & wmask) : b_ext;
    end

    // One iteration of either algorithm over the {hi, lo} accumulator
    logic [XLEN:0]   sum, sh_hi, diff, hi_step;
    logic [XLEN-1:0] lo_step;

    always_comb begin
        sum   = hi_q + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
        sh_hi = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        diff  = sh_hi - {1'b0, opnd_q};
        if (div_q) begin
            if (diff[XLEN]) begin
                hi_step = sh_hi;
                lo_step = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                hi_step = diff;
                lo_step = {lo_q[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_step = {1'b0, sum[XLEN:1]};
            lo_step = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up on the final iteration; a zero divisor forces the all-ones quotient,
    // while the remainder naturally restores rs1 after re-applying the dividend sign.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, full_res, fix_res;
    logic [HW-1:0]     half_res;

    always_comb begin
        prod   = {hi_step[XLEN-1:0], lo_step};
        prod_s = neg_q ? ({(2*XLEN){1'b0}} - prod) : prod;
        quo_s  = neg_q ? ({XLEN{1'b0}} - lo_step) : lo_step;
        rem_s  = neg_q ? ({XLEN{1'b0}} - hi_step[XLEN-1:0]) : hi_step[XLEN-1:0];
        if (div_q) begin
            full_res = rem_q ? rem_s : ((opnd_q == {XLEN{1'b0}}) ? {XLEN{1'b1}} : quo_s);
            half_res = full_res[HW-1:0];
        end else begin
            full_res = high_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
            half_res = prod_s[XLEN-1:HW];
        end
        fix_res = word_q ? {{HW{half_res[HW-1]}}, half_res} : full_res;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit;
    logic [XLEN-1:0] early_res;

    always_comb begin
        early_hit = dec_is_div ? (b_ext == {XLEN{1'b0}})
                               : ((a_ext == {XLEN{1'b0}}) || (b_ext == {XLEN{1'b0}}));
        early_res = {XLEN{1'b0}};
        if (dec_is_div) begin
            early_res = dec_is_rem ? (dec_is_word ? {{HW{rs1[HW-1]}}, rs1[HW-1:0]} : rs1)
                                   : {XLEN{1'b1}};
        end
    end
`endif

    logic [CW-1:0] last_cnt;
    assign last_cnt = word_q ? CW'(HW - 1) : CW'(XLEN - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            word_q      <= 1'b0;
            div_q       <= 1'b0;
            rem_q       <= 1'b0;
            high_q      <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && dec_is_m) begin
                        cnt_q  <= '0;
                        hi_q   <= '0;
                        word_q <= dec_is_word;
                        div_q  <= dec_is_div;
                        rem_q  <= dec_is_rem;
                        high_q <= dec_is_high;
                        neg_q  <= dec_is_rem ? a_neg : (a_neg ^ b_neg);
                        if (dec_is_div) begin
                            lo_q   <= dec_is_word ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
                            opnd_q <= b_mag;
                        end else begin
                            lo_q   <= b_mag;
                            opnd_q <= a_mag;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            state_q     <= S_DONE;
                            result_q    <= early_res;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                        end
`else
                        state_q <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    hi_q <= hi_step;
                    lo_q <= lo_step;
                    if (cnt_q == last_cnt) begin
                        state_q     <= S_DONE;
                        result_q    <= fix_res;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
